// File: rtl/cordic_mac_vec.sv
// Dot-product MAC: N sequential element products computed with a linear-mode
// CORDIC shift-add multiplier, summed into a saturating, optionally chained
// accumulator.
module cordic_mac_vec #(
  parameter int unsigned DW = 8,
  parameter int unsigned N  = 8,
  localparam int unsigned IW = $clog2(N),
  localparam int unsigned AW = 2 * DW + IW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          chain,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] w_in,
  output logic [IW-1:0] idx,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] acc_out,
  output logic          ovf
);

  // Iteration counter width; it counts 0..DW-1.
  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
  localparam int unsigned PW = 2 * DW;

  typedef enum logic [2:0] {StIdle, StLoad, StIter, StAcc, StDone} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] x_q, z_q;
  logic [PW-1:0] y_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic [AW-1:0] acc_q;
  logic          ovf_q;

  logic [CW-1:0] bit_sel;
  logic [PW-1:0] x_ext;
  logic [PW-1:0] x_shifted;
  logic [AW:0]   acc_sum;
  logic          last_iter;
  logic          last_elem;

  // Shift-add and accumulate helpers: iteration k uses bit DW-1-k of z.
  always_comb begin
    bit_sel   = CW'(DW - 1) - cnt_q;
    x_ext     = {{DW{1'b0}}, x_q};
    x_shifted = x_ext << bit_sel;
    acc_sum   = {1'b0, acc_q} + (AW + 1)'(y_q);
    last_iter = (cnt_q == CW'(DW - 1));
    last_elem = (idx_q == IW'(N - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in idle, so requests while busy are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StLoad;
      StLoad: state_d = StIter;
      StIter: if (last_iter) state_d = StAcc;
      StAcc:  state_d = last_elem ? StDone : StLoad;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  // Datapath: operand capture, shift-add multiply, saturating accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      z_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            idx_q <= '0;
            if (!chain) begin
              acc_q <= '0;
              ovf_q <= 1'b0;
            end
          end
        end
        StLoad: begin
          x_q   <= a_in;
          z_q   <= w_in;
          y_q   <= '0;
          cnt_q <= '0;
        end
        StIter: begin
          if (z_q[bit_sel]) y_q <= y_q + x_shifted;
          cnt_q <= cnt_q + CW'(1);
        end
        StAcc: begin
          // Once saturated the sum stays at full scale; adding >= 0 cannot bring it back.
          if (acc_sum[AW]) begin
            acc_q <= '1;
            ovf_q <= 1'b1;
          end else begin
            acc_q <= acc_sum[AW-1:0];
          end
          if (!last_elem) idx_q <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign idx     = idx_q;
  assign acc_out = acc_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_cordic_mac_vec.sv
// Directed bench for cordic_mac_vec: default instance plus a DW=4, N=2 instance.
module tb_cordic_mac_vec;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance (DW=8, N=8, AW=19)
  logic        start = 1'b0;
  logic        chain = 1'b0;
  logic [7:0]  a_mem [8];
  logic [7:0]  w_mem [8];
  logic [2:0]  idx;
  logic [7:0]  a_in, w_in;
  logic        busy, done, ovf;
  logic [18:0] acc_out;

  assign a_in = a_mem[idx];
  assign w_in = w_mem[idx];

  cordic_mac_vec u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chain(chain), .a_in(a_in), .w_in(w_in),
    .idx(idx), .busy(busy), .done(done), .acc_out(acc_out), .ovf(ovf)
  );

  // Small instance (DW=4, N=2, AW=9)
  logic        s_start = 1'b0;
  logic        s_chain = 1'b0;
  logic [3:0]  s_a_mem [2];
  logic [3:0]  s_w_mem [2];
  logic [0:0]  s_idx;
  logic [3:0]  s_a_in, s_w_in;
  logic        s_busy, s_done, s_ovf;
  logic [8:0]  s_acc;

  assign s_a_in = s_a_mem[s_idx];
  assign s_w_in = s_w_mem[s_idx];

  cordic_mac_vec #(.DW(4), .N(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .chain(s_chain), .a_in(s_a_in),
    .w_in(s_w_in), .idx(s_idx), .busy(s_busy), .done(s_done), .acc_out(s_acc), .ovf(s_ovf)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_a [8] = '{8'd23, 8'd58, 8'd25, 8'd46, 8'd51, 8'd76, 8'd18, 8'd92};
  logic [7:0] ref_w [8] = '{8'd45, 8'd36, 8'd15, 8'd59, 8'd56, 8'd109, 8'd108, 8'd35};

  task load_ref();
    for (int i = 0; i < 8; i++) begin
      a_mem[i] = ref_a[i];
      w_mem[i] = ref_w[i];
    end
  endtask

  task load_fill(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      a_mem[i] = v;
      w_mem[i] = v;
    end
  endtask

  // Start a run (optionally releasing reset at the same time), then wait for done.
  // done_at counts edges after the start-sampling edge; done_at = e means done is
  // high just before edge e. Returns positioned just before edge done_at (0 on timeout).
  task do_run(input logic ch, input int ign1, input int ign2, input logic rel,
              output int done_at);
    done_at = 0;
    @(negedge clk);
    start = 1'b1;
    chain = ch;
    if (rel) rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      start = (e == ign1) || (e == ign2);
      if (done) begin
        done_at = e;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({idx, busy, done, ovf} !== 6'd0 || acc_out !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: idx=%0d busy=%0b done=%0b acc=%0d ovf=%0b, want all 0",
               idx, busy, done, acc_out, ovf);
    end
    checks++;
    if ({s_idx, s_busy, s_done, s_ovf} !== 4'd0 || s_acc !== 9'd0) begin
      errors++;
      $display("FAIL reset_state_small: busy=%0b done=%0b acc=%0d, want 0", s_busy, s_done,
               s_acc);
    end
  endtask

  task test_release_start();
    int at;
    load_ref();
    do_run(1'b0, 0, 0, 1'b1, at);
    checks++;
    if (at !== 81 || acc_out !== 19'd22516) begin
      errors++;
      $display("FAIL release_start: done_at=%0d acc=%0d, want 81 / 22516", at, acc_out);
    end
  endtask

  task test_basic();
    int at;
    load_ref();
    do_run(1'b0, 0, 0, 1'b0, at);
    checks++;
    if (at !== 81) begin
      errors++;
      $display("FAIL basic_latency: done_at=%0d, want 81", at);
    end
    checks++;
    if (acc_out !== 19'd22516 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: acc=%0d ovf=%0b, want 22516 / 0", acc_out, ovf);
    end
    checks++;
    if (idx !== 3'd7 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_state: idx=%0d busy=%0b, want 7 / 1", idx, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || acc_out !== 19'd22516 || idx !== 3'd7) begin
      errors++;
      $display("FAIL basic_hold: done=%0b busy=%0b acc=%0d idx=%0d, want 0/0/22516/7",
               done, busy, acc_out, idx);
    end
  endtask

  task test_chain();
    int at;
    load_ref();
    do_run(1'b1, 0, 0, 1'b0, at);
    checks++;
    if (at !== 81 || acc_out !== 19'd45032 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL chain_sum: done_at=%0d acc=%0d ovf=%0b, want 81 / 45032 / 0",
               at, acc_out, ovf);
    end
  endtask

  task test_saturate();
    int at;
    load_fill(8'd255);
    do_run(1'b0, 0, 0, 1'b0, at);
    checks++;
    if (at !== 81 || acc_out !== 19'd520200 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL max_operands: done_at=%0d acc=%0d ovf=%0b, want 81 / 520200 / 0",
               at, acc_out, ovf);
    end
    do_run(1'b1, 0, 0, 1'b0, at);
    checks++;
    if (acc_out !== 19'd524287 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL saturate: acc=%0d ovf=%0b, want 524287 / 1", acc_out, ovf);
    end
    load_fill(8'd0);
    do_run(1'b0, 0, 0, 1'b0, at);
    checks++;
    if (at !== 81 || acc_out !== 19'd0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL zero_operands: done_at=%0d acc=%0d ovf=%0b, want 81 / 0 / 0",
               at, acc_out, ovf);
    end
  endtask

  task test_start_ignored();
    int at;
    load_ref();
    do_run(1'b0, 10, 40, 1'b0, at);
    checks++;
    if (at !== 81 || acc_out !== 19'd22516) begin
      errors++;
      $display("FAIL start_while_busy: done_at=%0d acc=%0d, want 81 / 22516", at, acc_out);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL no_queued_run: busy=%0b done=%0b, want 0 / 0", busy, done);
    end
  endtask

  task test_reset_mid_run();
    int at;
    int seen;
    load_ref();
    @(negedge clk);
    start = 1'b1;
    chain = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({idx, busy, done, ovf} !== 6'd0 || acc_out !== 19'd0) begin
      errors++;
      $display("FAIL async_reset: idx=%0d busy=%0b done=%0b acc=%0d ovf=%0b, want all 0",
               idx, busy, done, acc_out, ovf);
    end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL aborted_no_done: done seen %0d times, want 0", seen);
    end
    do_run(1'b1, 0, 0, 1'b1, at);
    checks++;
    if (at !== 81 || acc_out !== 19'd22516 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_chain: done_at=%0d acc=%0d ovf=%0b, want 81 / 22516 / 0",
               at, acc_out, ovf);
    end
  endtask

  task test_back_to_back();
    int at;
    load_ref();
    @(negedge clk);
    start = 1'b1;
    chain = 1'b0;
    @(negedge clk);
    at = 0;
    for (int e = 1; e <= 200; e++) begin
      if (done) begin
        at = e;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (at !== 81) begin
      errors++;
      $display("FAIL b2b_first_done: done_at=%0d, want 81", at);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: busy=%0b, want 0", busy);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || idx !== 3'd0) begin
      errors++;
      $display("FAIL b2b_restart: busy=%0b idx=%0d, want 1 / 0", busy, idx);
    end
    at = 0;
    for (int e = 1; e <= 200; e++) begin
      if (done) begin
        at = e;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (at !== 81 || acc_out !== 19'd22516) begin
      errors++;
      $display("FAIL b2b_second: done_at=%0d acc=%0d, want 81 / 22516", at, acc_out);
    end
  endtask

  task test_sweep();
    int at;
    s_a_mem[0] = 4'd15; s_w_mem[0] = 4'd15;
    s_a_mem[1] = 4'd7;  s_w_mem[1] = 4'd9;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      s_start = 1'b1;
      s_chain = (r == 1);
      @(negedge clk);
      s_start = 1'b0;
      at = 0;
      for (int e = 1; e <= 100; e++) begin
        if (s_done) begin
          at = e;
          break;
        end
        @(negedge clk);
      end
      if (r == 0) begin
        checks++;
        if (at !== 13 || s_acc !== 9'd288 || s_ovf !== 1'b0) begin
          errors++;
          $display("FAIL sweep_dw4_n2: done_at=%0d acc=%0d ovf=%0b, want 13 / 288 / 0",
                   at, s_acc, s_ovf);
        end
      end else begin
        checks++;
        if (at !== 13 || s_acc !== 9'd511 || s_ovf !== 1'b1) begin
          errors++;
          $display("FAIL sweep_saturate: done_at=%0d acc=%0d ovf=%0b, want 13 / 511 / 1",
                   at, s_acc, s_ovf);
        end
      end
    end
  endtask

  initial begin
    load_ref();
    s_a_mem[0] = 4'd0; s_a_mem[1] = 4'd0;
    s_w_mem[0] = 4'd0; s_w_mem[1] = 4'd0;
    test_reset();
    test_release_start();
    test_basic();
    test_chain();
    test_saturate();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
